// File: rtl/jt5205_pkg.sv
// jt5205_pkg: shared constants for the JT5205 ADPCM encoder/decoder pair.
// Holds the MSM5205 step table, index adjust table, limits and encoder FSM states.
`default_nettype none

package jt5205_pkg;

    localparam int IDX_MAX = 48;
    localparam int PCM_MIN = -2048;
    localparam int PCM_MAX = 2047;

    localparam logic [10:0] STEP_TBL [49] = '{
        11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,
        11'd31,   11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,
        11'd60,   11'd66,   11'd73,   11'd80,   11'd88,   11'd97,   11'd107,
        11'd118,  11'd130,  11'd143,  11'd157,  11'd173,  11'd190,  11'd209,
        11'd230,  11'd253,  11'd279,  11'd307,  11'd337,  11'd371,  11'd408,
        11'd449,  11'd494,  11'd544,  11'd598,  11'd658,  11'd724,  11'd796,
        11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411, 11'd1552
    };

    // Indexed by the magnitude bits {b2,b1,b0} of the code.
    localparam logic signed [4:0] ADJ_TBL [8] = '{
        -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd4, 5'sd6, 5'sd8
    };

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DIFF = 3'd1,
        ST_B2   = 3'd2,
        ST_B1   = 3'd3,
        ST_B0   = 3'd4,
        ST_UPD  = 3'd5,
        ST_OUT  = 3'd6
    } enc_state_e;

endpackage

`default_nettype wire

// File: rtl/jt5205_enc_if.sv
// jt5205_enc_if: PCM input and ADPCM nibble output handshakes of jt5205_enc.
// recon is present only when JT5205_ENC_RECON_EN is defined.
`default_nettype none

interface jt5205_enc_if;
    logic [11:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [3:0]  nib;
    logic        nib_valid;
    logic        nib_ready;
`ifdef JT5205_ENC_RECON_EN
    logic [11:0] recon;
`endif

    modport master (
        output din, din_valid, nib_ready,
`ifdef JT5205_ENC_RECON_EN
        input  recon,
`endif
        input  din_ready, nib, nib_valid
    );

    modport slave (
        input  din, din_valid, nib_ready,
`ifdef JT5205_ENC_RECON_EN
        output recon,
`endif
        output din_ready, nib, nib_valid
    );
endinterface

`default_nettype wire

// File: rtl/jt5205_enc_steptbl.sv
// jt5205_enc_steptbl: combinational step-size ROM, 6-bit index to 11-bit step.
// Out-of-range indices return the largest step.
`default_nettype none

module jt5205_enc_steptbl
    import jt5205_pkg::*;
(
    input  logic [5:0]  idx_i,
    output logic [10:0] step_o
);

    always_comb begin
        step_o = STEP_TBL[IDX_MAX];
        for (int i = 0; i <= IDX_MAX; i++) begin
            if (idx_i == i[5:0]) begin
                step_o = STEP_TBL[i];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/jt5205_enc.sv
// jt5205_enc: OKI 4-bit ADPCM encoder, one code bit per cen step, decoder-exact predictor.
// Define JT5205_ENC_RECON_EN to expose the reconstructed sample on bus.recon.
`default_nettype none

module jt5205_enc
    import jt5205_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           cen,
    jt5205_enc_if.slave    bus
);

    enc_state_e         state_q, state_d;
    logic signed [12:0] d_q, d_d;
    logic [12:0]        a_q, a_d;
    logic [10:0]        step_q, step_d;
    logic               sign_q, sign_d;
    logic               b2_q, b2_d;
    logic               b1_q, b1_d;
    logic               b0_q, b0_d;
    logic signed [11:0] pred_q, pred_d;
    logic [5:0]         idx_q, idx_d;

    logic [10:0]        tbl_step;
    logic [11:0]        delta;
    logic signed [13:0] pred_ext, delta_ext, pred_sum;
    logic signed [4:0]  adj;
    logic signed [7:0]  idx_sum;
    logic signed [11:0] pred_sat;
    logic [5:0]         idx_clamp;

    jt5205_enc_steptbl u_steptbl (
        .idx_i  (idx_q),
        .step_o (tbl_step)
    );

    // Reconstruction delta: the decoder adds step/8 so that a zero code still moves.
    always_comb begin
        delta = {4'b0000, step_q[10:3]}
              + (b2_q ? {1'b0, step_q}        : 12'd0)
              + (b1_q ? {2'b00, step_q[10:1]} : 12'd0)
              + (b0_q ? {3'b000, step_q[10:2]} : 12'd0);
        pred_ext  = {{2{pred_q[11]}}, pred_q};
        delta_ext = {2'b00, delta};
        pred_sum  = sign_q ? (pred_ext - delta_ext) : (pred_ext + delta_ext);
        if (int'(pred_sum) > PCM_MAX) begin
            pred_sat = 12'sd2047;
        end else if (int'(pred_sum) < PCM_MIN) begin
            pred_sat = -12'sd2048;
        end else begin
            pred_sat = pred_sum[11:0];
        end

        adj     = ADJ_TBL[{b2_q, b1_q, b0_q}];
        idx_sum = {2'b00, idx_q} + {{3{adj[4]}}, adj};
        if (int'(idx_sum) < 0) begin
            idx_clamp = 6'd0;
        end else if (int'(idx_sum) > IDX_MAX) begin
            idx_clamp = 6'(IDX_MAX);
        end else begin
            idx_clamp = idx_sum[5:0];
        end
    end

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        a_d     = a_q;
        step_d  = step_q;
        sign_d  = sign_q;
        b2_d    = b2_q;
        b1_d    = b1_q;
        b0_d    = b0_q;
        pred_d  = pred_q;
        idx_d   = idx_q;

        case (state_q)
            ST_IDLE: begin
                if (cen && bus.din_valid) begin
                    d_d     = $signed({bus.din[11], bus.din}) - $signed({pred_q[11], pred_q});
                    state_d = ST_DIFF;
                end
            end
            ST_DIFF: begin
                if (cen) begin
                    sign_d  = d_q[12];
                    a_d     = d_q[12] ? 13'(-d_q) : 13'(d_q);
                    step_d  = tbl_step;
                    state_d = ST_B2;
                end
            end
            ST_B2: begin
                if (cen) begin
                    b2_d = (a_q >= {2'b00, step_q});
                    if (b2_d) a_d = a_q - {2'b00, step_q};
                    state_d = ST_B1;
                end
            end
            ST_B1: begin
                if (cen) begin
                    b1_d = (a_q >= {3'b000, step_q[10:1]});
                    if (b1_d) a_d = a_q - {3'b000, step_q[10:1]};
                    state_d = ST_B0;
                end
            end
            ST_B0: begin
                if (cen) begin
                    b0_d    = (a_q >= {4'b0000, step_q[10:2]});
                    state_d = ST_UPD;
                end
            end
            ST_UPD: begin
                if (cen) begin
                    pred_d  = pred_sat;
                    idx_d   = idx_clamp;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                // Output handshake is deliberately independent of cen.
                if (bus.nib_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            d_q     <= '0;
            a_q     <= '0;
            step_q  <= '0;
            sign_q  <= 1'b0;
            b2_q    <= 1'b0;
            b1_q    <= 1'b0;
            b0_q    <= 1'b0;
            pred_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            a_q     <= a_d;
            step_q  <= step_d;
            sign_q  <= sign_d;
            b2_q    <= b2_d;
            b1_q    <= b1_d;
            b0_q    <= b0_d;
            pred_q  <= pred_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.din_ready = (state_q == ST_IDLE) && !rst;
    assign bus.nib_valid = (state_q == ST_OUT);
    assign bus.nib       = {sign_q, b2_q, b1_q, b0_q};
`ifdef JT5205_ENC_RECON_EN
    assign bus.recon     = pred_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_jt5205_enc.sv
// tb_jt5205_enc: directed self-checking bench for jt5205_enc with hand-computed codes.
// Checks bus.recon as well when JT5205_ENC_RECON_EN is defined.
`default_nettype none

module tb_jt5205_enc;
    import jt5205_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cen = 1'b1;
    always #5 clk = ~clk;

    jt5205_enc_if bus ();

    jt5205_enc dut (
        .clk (clk),
        .rst (rst),
        .cen (cen),
        .bus (bus)
    );

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int cen_div = 1;
    int m_pred  = 0;
    int m_idx   = 0;

    int tb_step [49] = '{16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45, 50, 55,
                         60, 66, 73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190,
                         209, 230, 253, 279, 307, 337, 371, 408, 449, 494, 544, 598,
                         658, 724, 796, 876, 963, 1060, 1166, 1282, 1411, 1552};

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        cen = ((cyc % cen_div) == 0);
    endtask

    task automatic model(input int x, inout int p, inout int ix, output logic [3:0] n);
        int d, a, st, dl;
        logic sg, b2, b1, b0;
        st = tb_step[ix];
        d  = x - p;
        sg = (d < 0);
        a  = sg ? -d : d;
        b2 = (a >= st);       if (b2) a = a - st;
        b1 = (a >= st / 2);   if (b1) a = a - st / 2;
        b0 = (a >= st / 4);
        dl = st / 8 + (b2 ? st : 0) + (b1 ? st / 2 : 0) + (b0 ? st / 4 : 0);
        p  = sg ? p - dl : p + dl;
        if (p > 2047) p = 2047;
        if (p < -2048) p = -2048;
        case ({b2, b1, b0})
            3'b100:  ix = ix + 2;
            3'b101:  ix = ix + 4;
            3'b110:  ix = ix + 6;
            3'b111:  ix = ix + 8;
            default: ix = ix - 1;
        endcase
        if (ix < 0) ix = 0;
        if (ix > 48) ix = 48;
        n = {sg, b2, b1, b0};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.din_valid = 1'b0;
        bus.nib_ready = 1'b1;
        step();
        step();
        chk("rst_din_ready", 32'(bus.din_ready), 0);
        chk("rst_nib_valid", 32'(bus.nib_valid), 0);
        chk("rst_nib", 32'(bus.nib), 0);
        chk("rst_pred", 32'(dut.pred_q), 0);
        chk("rst_idx", 32'(dut.idx_q), 0);
        rst = 1'b0;
        step();
        chk("idle_din_ready", 32'(bus.din_ready), 1);
        m_pred = 0;
        m_idx  = 0;
    endtask

    // Offer x until accepted, then wait for nib_valid counting cen pulses after accept.
    task automatic send(input int x, output logic [3:0] n, output int lat);
        int k;
        bus.din       = 12'(x);
        bus.din_valid = 1'b1;
        k = 0;
        while (!(bus.din_ready && cen) && k < 200) begin
            step();
            k++;
        end
        chk("accept_bound", 32'(k < 200), 1);
        step();
        bus.din_valid = 1'b0;
        lat = 0;
        k   = 0;
        while (!bus.nib_valid && k < 400) begin
            if (cen) lat++;
            step();
            k++;
        end
        chk("nib_valid_bound", 32'(k < 400), 1);
        n = bus.nib;
    endtask

    task automatic do_sample(input string tag, input int x);
        logic [3:0] n, en;
        int lat;
        send(x, n, lat);
        model(x, m_pred, m_idx, en);
        chk({tag, "_nib"}, 32'(n), 32'(en));
        chk({tag, "_lat"}, lat, 5);
        chk({tag, "_pred"}, 32'(dut.pred_q), m_pred);
        chk({tag, "_idx"}, 32'(dut.idx_q), m_idx);
`ifdef JT5205_ENC_RECON_EN
        chk({tag, "_recon"}, 32'($signed(bus.recon)), m_pred);
`endif
        step();
        chk({tag, "_nib_valid_fall"}, 32'(bus.nib_valid), 0);
    endtask

    initial begin
        logic [3:0] n;
        int lat;
        bus.din       = '0;
        bus.din_valid = 1'b0;
        bus.nib_ready = 1'b1;

        // Basic vectors from reset.
        do_reset();
        do_sample("p256", 256);
        chk("p256_hand_nib", 32'(bus.nib), 32'h7);
        chk("p256_hand_pred", 32'(dut.pred_q), 30);
        chk("p256_hand_idx", 32'(dut.idx_q), 8);

        do_reset();
        do_sample("m2048", -2048);
        chk("m2048_hand_nib", 32'(bus.nib), 32'hF);
        chk("m2048_hand_pred", 32'(dut.pred_q), -30);
        chk("m2048_hand_idx", 32'(dut.idx_q), 8);

        do_reset();
        do_sample("zero", 0);
        chk("zero_hand_nib", 32'(bus.nib), 0);
        chk("zero_hand_pred", 32'(dut.pred_q), 2);
        chk("zero_hand_idx", 32'(dut.idx_q), 0);

        // Positive full scale: predictor saturates at 2047, then zero codes drain idx.
        do_reset();
        for (int i = 0; i < 60; i++) do_sample("sat_pos", 2047);
        chk("sat_pos_final_pred", 32'(dut.pred_q), 2047);
        chk("sat_pos_final_idx", 32'(dut.idx_q), 0);

        // Alternating extremes drive idx into the upper clamp.
        do_reset();
        for (int i = 0; i < 6; i++) do_sample("alt", (i % 2 == 0) ? 2047 : -2048);
        chk("alt_hand_idx48", 32'(dut.idx_q), 48);
        chk("alt_hand_pred", 32'(dut.pred_q), -916);
        do_sample("alt_clamp", 2047);
        chk("alt_clamp_nib", 32'(bus.nib), 32'h7);
        chk("alt_clamp_idx", 32'(dut.idx_q), 48);
        chk("alt_clamp_pred", 32'(dut.pred_q), 1994);
        for (int i = 0; i < 10; i++) do_sample("alt_more", (i % 2 == 0) ? -2048 : 2047);

        // Backpressure in OUT.
        do_reset();
        bus.nib_ready = 1'b0;
        send(256, n, lat);
        chk("bp_nib", 32'(n), 32'h7);
        bus.din       = 12'd100;
        bus.din_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_hold_nib", 32'(bus.nib), 32'h7);
            chk("bp_hold_valid", 32'(bus.nib_valid), 1);
            chk("bp_din_ready", 32'(bus.din_ready), 0);
        end
        bus.nib_ready = 1'b1;
        step();
        bus.din_valid = 1'b0;
        chk("bp_release_valid", 32'(bus.nib_valid), 0);
        chk("bp_release_din_ready", 32'(bus.din_ready), 1);
        chk("bp_no_accept_pred", 32'(dut.pred_q), 30);

        // Reset while in B1.
        do_reset();
        bus.din       = 12'd256;
        bus.din_valid = 1'b1;
        step();
        bus.din_valid = 1'b0;
        step();
        step();
        chk("b1_state", 32'(dut.state_q), 32'(ST_B1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("b1_rst_nib_valid", 32'(bus.nib_valid), 0);
        chk("b1_rst_pred", 32'(dut.pred_q), 0);
        chk("b1_rst_idx", 32'(dut.idx_q), 0);
        step();
        m_pred = 0;
        m_idx  = 0;
        do_sample("b1_after", 256);
        chk("b1_after_hand_nib", 32'(bus.nib), 32'h7);

        // Quarter-rate clock enable: same codes, same cen latency.
        do_reset();
        cen_div = 4;
        do_sample("q256", 256);
        chk("q256_hand_nib", 32'(bus.nib), 32'h7);
        do_sample("q_m2048", -2048);
        do_sample("q_1000", 1000);
        cen_div = 1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
